// File: rtl/rec_patron_param.sv
// rec_patron_param: serial symbol pattern recogniser with runtime-loadable
// pattern, overlap/non-overlap detection and a saturating match counter.
module rec_patron_param #(
    parameter int SYM_W   = 1,
    parameter int PAT_LEN = 4,
    parameter logic [PAT_LEN*SYM_W-1:0] RESET_PAT = 4'b0101,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             overlap,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic             cnt_clr,
    output logic             match,
    output logic             hist_full,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int HW     = PAT_LEN * SYM_W;
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    logic [HW-1:0]     hist;
    logic [HW-1:0]     hist_nx;
    logic [HW-1:0]     pat;
    logic [HW-1:0]     pat_nx;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nx;
    logic              hit;
    logic              accept;

    // Newest symbol lands at index PAT_LEN-1, matching pattern layout.
    always_comb begin
        accept  = in_valid && !cfg_we;
        hist_nx = {in_sym, hist[HW-1:SYM_W]};
        fill_nx = (fill == FULL) ? FULL : fill + FILL_W'(1);
        hit     = (fill_nx == FULL) && (hist_nx == pat);
        pat_nx  = pat;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (cfg_idx == IDX_W'(i))
                pat_nx[i*SYM_W +: SYM_W] = cfg_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat       <= RESET_PAT;
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            hist_full <= 1'b0;
            match_cnt <= '0;
        end else begin
            match     <= 1'b0;
            hist_full <= (fill == FULL);
            if (cfg_we) begin
                pat       <= pat_nx;
                hist      <= '0;
                fill      <= '0;
                hist_full <= 1'b0;
            end else if (in_valid) begin
                hist      <= hist_nx;
                match     <= hit;
                hist_full <= (fill_nx == FULL);
                fill      <= (hit && !overlap) ? '0 : fill_nx;
            end
            // Clear beats a coincident hit.
            if (cnt_clr)
                match_cnt <= '0;
            else if (accept && hit && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rec_patron_param.sv
// Bench for rec_patron_param: directed scenarios on two configurations
// plus a randomized stream checked against a queue-based model.
module tb_rec_patron_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_sym = '0;
    logic       overlap = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [1:0] cfg_sym = '0;
    logic       cnt_clr = 1'b0;

    logic       match_a, full_a;
    logic [1:0] cnt_a;
    logic       match_b, full_b;
    logic [7:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for the 2-bit, length-3 instance.
    int mq[$];
    int mpat[3];
    int mfill;
    int mcnt;
    int mm;
    int mfull;

    always #5 clk = ~clk;

    rec_patron_param #(
        .SYM_W(1), .PAT_LEN(4), .RESET_PAT(4'b0101), .CNT_W(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_sym(in_sym[0]), .overlap(overlap), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_sym(cfg_sym[0]), .cnt_clr(cnt_clr),
        .match(match_a), .hist_full(full_a), .match_cnt(cnt_a)
    );

    rec_patron_param #(
        .SYM_W(2), .PAT_LEN(3), .RESET_PAT(6'b000000), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_sym(in_sym), .overlap(overlap), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .cnt_clr(cnt_clr),
        .match(match_b), .hist_full(full_b), .match_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] s,
                       input logic we, input logic [1:0] idx,
                       input logic [1:0] cs, input logic clr);
        in_valid = v;
        in_sym   = s;
        cfg_we   = we;
        cfg_idx  = idx;
        cfg_sym  = cs;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] s);
        cyc(1'b1, s, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        mpat  = '{0, 0, 0};
        mfill = 0;
        mcnt  = 0;
        mm    = 0;
        mfull = 0;
    endtask

    task automatic model_step(input int v, input int s, input int ovl,
                              input int we, input int idx, input int cs,
                              input int clr);
        int hit;
        hit = 0;
        mm  = 0;
        if (we != 0) begin
            mpat[idx] = cs;
            mq.delete();
            mfill = 0;
            mfull = 0;
        end else if (v != 0) begin
            mq.push_back(s);
            if (mq.size() > 3) void'(mq.pop_front());
            mfill = (mfill < 3) ? mfill + 1 : 3;
            mfull = (mfill == 3);
            if (mfill == 3) begin
                hit = 1;
                for (int i = 0; i < 3; i++)
                    if (mq[i] != mpat[i]) hit = 0;
            end
            mm = hit;
            if (hit != 0 && ovl == 0) mfill = 0;
        end else begin
            mfull = (mfill == 3);
        end
        if (clr != 0) mcnt = 0;
        else if (hit != 0 && mcnt < 255) mcnt++;
    endtask

    initial begin
        int s8[8];
        int r_v, r_s, r_o, r_we, r_i, r_cs, r_c;
        s8 = '{1, 0, 1, 0, 1, 0, 1, 0};

        // Reset state
        do_reset();
        chk("rst_match", match_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_cnt", cnt_a, 0);

        // Overlapping "bababa"
        overlap = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sym(2'(s8[k]));
            chk($sformatf("ovl_match%0d", k), match_a, (k == 3 || k == 5));
            chk($sformatf("ovl_full%0d", k), full_a, (k >= 3));
        end
        chk("ovl_cnt", cnt_a, 2);
        idle();
        chk("ovl_idle_match", match_a, 0);
        chk("ovl_idle_full", full_a, 1);

        // Non-overlapping "babababa"
        do_reset();
        overlap = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sym(2'(s8[k]));
            chk($sformatf("novl_match%0d", k), match_a, (k == 3 || k == 7));
            chk($sformatf("novl_full%0d", k), full_a, (k == 3 || k == 7));
        end
        chk("novl_cnt", cnt_a, 2);

        // Reset mid-stream with a match in flight
        do_reset();
        overlap = 1'b1;
        for (int k = 0; k < 4; k++) sym(2'(s8[k]));
        chk("mid_pre_match", match_a, 1);
        chk("mid_pre_cnt", cnt_a, 1);
        rst_n = 1'b0;
        sym(2'd1);
        rst_n = 1'b1;
        chk("mid_rst_match", match_a, 0);
        chk("mid_rst_full", full_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        sym(2'd0);
        chk("mid_a_match", match_a, 0);
        chk("mid_a_full", full_a, 0);
        sym(2'd1);
        sym(2'd0);
        chk("mid_3_full", full_a, 0);
        sym(2'd1);
        chk("mid_4_full", full_a, 1);
        chk("mid_4_match", match_a, 0);
        sym(2'd0);
        chk("mid_5_match", match_a, 1);

        // Saturation at 3 and clear against a coincident hit
        do_reset();
        overlap = 1'b1;
        for (int k = 0; k < 12; k++) sym(2'(s8[k % 8]));
        chk("sat_cnt", cnt_a, 3);
        sym(2'd1);
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1);
        chk("clr_match", match_a, 1);
        chk("clr_cnt", cnt_a, 0);

        // Reconfigure the 2-bit instance to 3,0,2
        do_reset();
        cyc(1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0);
        chk("cfg_match", match_b, 0);
        begin
            int st[6];
            st = '{3, 0, 2, 3, 0, 2};
            for (int k = 0; k < 6; k++) begin
                sym(2'(st[k]));
                chk($sformatf("rc_match%0d", k), match_b,
                    (k == 2 || k == 5));
                idle();
                chk($sformatf("rc_gap%0d", k), match_b, 0);
            end
        end
        chk("rc_cnt", cnt_b, 2);
        sym(2'd3);
        sym(2'd0);
        cyc(1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0);
        chk("cfgv_match", match_b, 0);
        chk("cfgv_full", full_b, 0);
        sym(2'd2);
        chk("cfgv_next_match", match_b, 0);
        chk("cfgv_cnt", cnt_b, 2);

        // Random stream against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 10000; i++) begin
            r_v  = ($urandom_range(0, 3) != 0);
            r_s  = $urandom_range(0, 3);
            r_o  = $urandom_range(0, 1);
            r_we = ($urandom_range(0, 99) == 0);
            r_i  = $urandom_range(0, 2);
            r_cs = $urandom_range(0, 3);
            r_c  = ($urandom_range(0, 29) == 0);
            overlap = r_o[0];
            model_step(r_v, r_s, r_o, r_we, r_i, r_cs, r_c);
            cyc(r_v[0], 2'(r_s), r_we[0], 2'(r_i), 2'(r_cs), r_c[0]);
            chk("rnd_match", match_b, mm);
            chk("rnd_full", full_b, mfull);
            chk("rnd_cnt", cnt_b, mcnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
